// File: rtl/beta_mem_loader_if.sv
// Stream-in and memory-write-port bundle for the beta boot loader.
// slave = loader side, master = host/memory side.
interface beta_mem_loader_if #(
  parameter int IM_AW = 10,
  parameter int DM_AW = 8,
  parameter int IW    = 32,
  parameter int DW    = 128
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [IW-1:0]    im_wdata;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [DW-1:0]    dm_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata
  );
endinterface

// File: rtl/beta_mem_loader.sv
// Boot loader: parses SYNC/TGT/CNT/payload/CHK sections from a byte stream,
// writes assembled words to imem/dmem and releases the beta core on start.
module beta_mem_loader #(
  parameter int         IM_AW = 10,
  parameter int         DM_AW = 8,
  parameter int         IW    = 32,
  parameter int         DW    = 128,
  parameter logic [7:0] SYNC  = 8'hA5
) (
  input  logic                clk,
  input  logic                RESET_N,
  beta_mem_loader_if.slave    bus,
  output logic                cpu_reset,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TGT,
    S_CNT_LO,
    S_CNT_HI,
    S_PAYLOAD,
    S_CHK,
    S_RUN
  } state_t;

  localparam int IM_BYTES = IW / 8;
  localparam int DM_BYTES = DW / 8;
  localparam int BCW      = $clog2(DM_BYTES + 1);
  localparam logic [BCW-1:0] IM_LAST = BCW'(IM_BYTES - 1);
  localparam logic [BCW-1:0] DM_LAST = BCW'(DM_BYTES - 1);

  state_t           state_q, state_d;
  logic             xfer;
  logic             tgt_dm_q;
  logic [7:0]       cnt_lo_q;
  logic [15:0]      cnt_q;
  logic [BCW-1:0]   byte_cnt_q;
  logic [DW-1:0]    word_q;
  logic [DW-1:0]    word_next;
  logic [7:0]       chk_q;
  logic [IM_AW-1:0] im_ptr_q;
  logic [DM_AW-1:0] dm_ptr_q;
  logic             word_done;
  logic             ready_d, run_d, im_wr, dm_wr, err_set;

  assign xfer      = bus.in_valid & bus.in_ready;
  // Bytes enter at the top, so an imem word ends up in the upper IW bits.
  assign word_next = {bus.in_data, word_q[DW-1:8]};
  assign word_done = (byte_cnt_q == (tgt_dm_q ? DM_LAST : IM_LAST));

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (xfer && bus.in_data == SYNC) state_d = S_TGT;
      S_TGT: begin
        if (xfer) begin
          if (bus.in_data == 8'h00 || bus.in_data == 8'h01) state_d = S_CNT_LO;
          else if (bus.in_data == 8'hFF && !err)              state_d = S_RUN;
          else                                                 state_d = S_IDLE;
        end
      end
      S_CNT_LO:  if (xfer) state_d = S_CNT_HI;
      S_CNT_HI: begin
        if (xfer) state_d = ({bus.in_data, cnt_lo_q} != 16'd0) ? S_PAYLOAD : S_CHK;
      end
      S_PAYLOAD: if (xfer && word_done && cnt_q == 16'd1) state_d = S_CHK;
      S_CHK:     if (xfer) state_d = S_IDLE;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d != S_RUN);
    run_d   = (state_d == S_RUN);
    im_wr   = (state_q == S_PAYLOAD) && xfer && word_done && !tgt_dm_q;
    dm_wr   = (state_q == S_PAYLOAD) && xfer && word_done && tgt_dm_q;
    err_set = 1'b0;
    if (xfer && state_q == S_TGT &&
        bus.in_data != 8'h00 && bus.in_data != 8'h01 && bus.in_data != 8'hFF)
      err_set = 1'b1;
    if (xfer && state_q == S_CHK && bus.in_data != chk_q)
      err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      bus.in_ready <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      bus.dm_we    <= 1'b0;
      bus.dm_addr  <= '0;
      bus.dm_wdata <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      tgt_dm_q     <= 1'b0;
      cnt_lo_q     <= '0;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      chk_q        <= '0;
      im_ptr_q     <= '0;
      dm_ptr_q     <= '0;
    end else begin
      bus.in_ready <= ready_d;
      cpu_reset    <= !run_d;
      done         <= run_d;
      bus.im_we    <= im_wr;
      bus.dm_we    <= dm_wr;
      if (err_set) err <= 1'b1;

      if (im_wr) begin
        bus.im_addr  <= im_ptr_q;
        bus.im_wdata <= word_next[DW-1 -: IW];
        im_ptr_q     <= im_ptr_q + 1'b1;
      end
      if (dm_wr) begin
        bus.dm_addr  <= dm_ptr_q;
        bus.dm_wdata <= word_next;
        dm_ptr_q     <= dm_ptr_q + 1'b1;
      end

      if (xfer) begin
        case (state_q)
          S_TGT: begin
            tgt_dm_q   <= bus.in_data[0];
            im_ptr_q   <= '0;
            dm_ptr_q   <= '0;
            chk_q      <= '0;
            byte_cnt_q <= '0;
          end
          S_CNT_LO: cnt_lo_q <= bus.in_data;
          S_CNT_HI: cnt_q    <= {bus.in_data, cnt_lo_q};
          S_PAYLOAD: begin
            word_q <= word_next;
            chk_q  <= chk_q ^ bus.in_data;
            if (word_done) begin
              byte_cnt_q <= '0;
              cnt_q      <= cnt_q - 16'd1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
